// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage that sits directly behind the ALU. A request carries the
//   effective address, the store data (rs2), funct3 and rd. The unit issues
//   one byte/half/word access on a req/ack data bus. It then returns one
//   single-cycle response to writeback. For loads the response holds the
//   aligned, extended data; for stores it is a completion. Misaligned
//   accesses and illegal funct3 are reported without any bus activity.
//   A bus that never acknowledges is reported as a timeout error.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we, req_funct3      store/load select and RV32I width/sign code
//   req_addr, req_wdata     effective address and store data
//   req_rd                  destination register, passed through
//   resp_valid              one-cycle completion pulse
//   resp_rdata/rd/wb/err    response payload
//   busy                    unit is not idle
//   mem_req/we/addr/be/wdata  data bus request, held stable until mem_ack
//   mem_ack, mem_rdata      bus completion and read word (same cycle)
//
// Every output is either a register or a decode of the state register.
// No req_* input and no mem_ack has a combinational path to an output.
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_wb,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_r, state_d;
  logic [9:0]  cnt_r, cnt_d;
  logic        op_we_r, op_we_d;
  logic [2:0]  op_funct3_r, op_funct3_d;
  logic [1:0]  op_off_r, op_off_d;
  logic [4:0]  op_rd_r, op_rd_d;

  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;
  logic        resp_valid_d, resp_wb_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [4:0]  resp_rd_d;

  // funct3 legality: stores only allow byte/half/word, loads add the unsigned forms
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // natural alignment check from the width bits of funct3
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // byte enables for the addressed lane(s)
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // store data replicated onto every lane so the byte enables pick it out
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      2'b10:   w = d;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // lane select plus sign/zero extension of the returned bus word
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // status outputs are pure state decodes
  assign req_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);

  // next-state and next-output logic
  always_comb begin
    state_d      = state_r;
    cnt_d        = cnt_r;
    op_we_d      = op_we_r;
    op_funct3_d  = op_funct3_r;
    op_off_d     = op_off_r;
    op_rd_d      = op_rd_r;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_be_d     = mem_be;
    mem_wdata_d  = mem_wdata;
    // response fields are nonzero only in the single RESP cycle
    resp_valid_d = 1'b0;
    resp_wb_d    = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    resp_rd_d    = 5'd0;

    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          op_we_d     = req_we;
          op_funct3_d = req_funct3;
          op_off_d    = req_addr[1:0];
          op_rd_d     = req_rd;
          if (is_legal(req_we, req_funct3) && is_aligned(req_funct3[1:0], req_addr[1:0])) begin
            state_d     = S_ACCESS;
            cnt_d       = 10'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = lane_be(req_funct3[1:0], req_addr[1:0]);
            mem_wdata_d = req_we ? store_data(req_funct3[1:0], req_wdata) : 32'd0;
          end else begin
            // rejected at accept time: straight to RESP, bus untouched
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = req_rd;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (mem_ack) begin
          // ack takes priority over a timeout in the same cycle
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'd0;
          mem_be_d     = 4'd0;
          mem_wdata_d  = 32'd0;
          resp_valid_d = 1'b1;
          if (op_we_r) begin
            resp_wb_d    = 1'b0;
            resp_rdata_d = 32'd0;
            resp_rd_d    = 5'd0;
          end else begin
            resp_wb_d    = 1'b1;
            resp_rdata_d = load_extract(op_funct3_r, op_off_r, mem_rdata);
            resp_rd_d    = op_rd_r;
          end
        end else if (({1'b0, cnt_r} + 11'd1) == 11'(MEM_TIMEOUT)) begin
          // this was the last allowed ACCESS cycle: mem_req was high MEM_TIMEOUT cycles
          state_d      = S_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'd0;
          mem_be_d     = 4'd0;
          mem_wdata_d  = 32'd0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rd_d    = op_rd_r;
        end else begin
          cnt_d = cnt_r + 10'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_be_d    = 4'd0;
        mem_wdata_d = 32'd0;
      end
    endcase
  end

  // state, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 10'd0;
      op_we_r     <= 1'b0;
      op_funct3_r <= 3'd0;
      op_off_r    <= 2'd0;
      op_rd_r     <= 5'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_be      <= 4'd0;
      mem_wdata   <= 32'd0;
      resp_valid  <= 1'b0;
      resp_wb     <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_rd     <= 5'd0;
    end else begin
      state_r     <= state_d;
      cnt_r       <= cnt_d;
      op_we_r     <= op_we_d;
      op_funct3_r <= op_funct3_d;
      op_off_r    <= op_off_d;
      op_rd_r     <= op_rd_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_be      <= mem_be_d;
      mem_wdata   <= mem_wdata_d;
      resp_valid  <= resp_valid_d;
      resp_wb     <= resp_wb_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
      resp_rd     <= resp_rd_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table plus response scoreboard,
// with hand-written sequences for reset, timeout and back-to-back traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n, reset_n2;
  logic        req_valid, req_valid2;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_wb, resp_err, busy, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [4:0]  resp_rd;
  logic [3:0]  mem_be;

  logic        req_ready2, resp_valid2, resp_wb2, resp_err2, busy2, mem_req2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
  logic [4:0]  resp_rd2;
  logic [3:0]  mem_be2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_wb(resp_wb), .resp_err(resp_err), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_n(reset_n2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_rd(resp_rd2),
    .resp_wb(resp_wb2), .resp_err(resp_err2), .busy(busy2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wb;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  dly;
    logic        bus;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [4:0]  e_rd;
    logic        e_wb;
    logic        e_err;
  } vec_t;

  resp_t exp_q[$];
  vec_t  vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: every response pulse of the main DUT is matched against the queue
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_rd", 32'(resp_rd), 32'(e.rd));
        chk("resp_wb", 32'(resp_wb), 32'(e.wb));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v);
    resp_t e;
    chk("ready_idle", 32'(req_ready), 32'd1);
    drive(v.we, v.f3, v.addr, v.wdata, v.rd);
    req_valid = 1'b1;
    e.rdata = v.e_rdata; e.rd = v.e_rd; e.wb = v.e_wb; e.err = v.e_err;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.bus) begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(v.we));
      chk("mem_addr", mem_addr, v.e_addr);
      chk("mem_be", 32'(mem_be), 32'(v.e_be));
      chk("mem_wdata", mem_wdata, v.e_wdata);
      for (int i = 0; i < int'(v.dly); i++) begin
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("hold_req", 32'(mem_req), 32'd1);
        chk("hold_addr", mem_addr, v.e_addr);
        chk("hold_be", 32'(mem_be), 32'(v.e_be));
        chk("hold_wdata", mem_wdata, v.e_wdata);
      end
      mem_ack = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end else begin
      chk("err_no_bus", 32'(mem_req), 32'd0);
    end
    chk("resp_pulse", 32'(resp_valid), 32'd1);
    chk("req_dropped", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("idle_again", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    logic got;
    resp_t e;

    //             we    f3      addr          wdata         rd     rdata         dly   bus   e_addr        e_be     e_wdata       e_rdata       e_rd   wb    err
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_7F01, 4'd0, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 5'd5,  1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5'd9,  32'h0,        4'd5, 1'b1, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 32'h0,        5'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        5'd3,  32'h0,        4'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd3,  1'b0, 1'b1};
    vecs[3]  = '{1'b1, 3'b011, 32'h0000_0100, 32'h1111_2222, 5'd4,  32'h0,        4'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd4,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0,        5'd6,  32'h8001_1234, 4'd1, 1'b1, 32'h0000_0004, 4'b1100, 32'h0,        32'hFFFF_8001, 5'd6,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'b100, 32'h0000_0005, 32'h0,        5'd8,  32'h0000_F000, 4'd0, 1'b1, 32'h0000_0004, 4'b0010, 32'h0,        32'h0000_00F0, 5'd8,  1'b1, 1'b0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0003, 32'hAAAA_AA55, 5'd1,  32'h0,        4'd0, 1'b1, 32'h0000_0000, 4'b1000, 32'h5555_5555, 32'h0,        5'd0,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 5'd2,  32'h0,        4'd2, 1'b1, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0,        5'd0,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,        5'd31, 32'h89AB_CDEF, 4'd2, 1'b1, 32'h0000_0004, 4'b1111, 32'h0,        32'h89AB_CDEF, 5'd31, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,        5'd10, 32'h0,        4'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd10, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'b110, 32'h0000_0000, 32'h0,        5'd11, 32'h0,        4'd0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd11, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        5'd12, 32'hFEDC_0000, 4'd0, 1'b1, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_FEDC, 5'd12, 1'b1, 1'b0};

    reset_n = 1'b0; reset_n2 = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in the second ACCESS cycle of an LW: no response, bus dropped
    drive(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd2);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_acc_drop", 32'(mem_req), 32'd0);
    chk("rst_acc_noresp", 32'(resp_valid), 32'd0);
    chk("rst_acc_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    run_vec('{1'b0, 3'b100, 32'h0000_0007, 32'h0, 5'd14, 32'h8000_0000, 4'd0, 1'b1,
              32'h0000_0004, 4'b1000, 32'h0, 32'h0000_0080, 5'd14, 1'b1, 1'b0});

    // back-to-back: request always valid, ack in the first ACCESS cycle
    drive(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd7);
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", 32'(req_ready), 32'((i % 3) == 0));
      if (req_ready) begin
        e.rdata = 32'hDEAD_BEEF; e.rd = 5'd7; e.wb = 1'b1; e.err = 1'b0;
        exp_q.push_back(e);
      end
      mem_ack = mem_req;
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);

    // timeout on the MEM_TIMEOUT=4 instance, then late ack and a normal request
    reset_n2 = 1'b1;
    @(negedge clk);
    drive(1'b0, 3'b101, 32'h0000_0040, 32'h0, 5'd11);
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req2) cnt++;
      if (resp_valid2) begin
        got = 1'b1;
        chk("to_err", 32'(resp_err2), 32'd1);
        chk("to_wb", 32'(resp_wb2), 32'd0);
        chk("to_rdata", resp_rdata2, 32'd0);
        chk("to_rd", 32'(resp_rd2), 32'd11);
      end
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(cnt), 32'd4);
    chk("to_resp_seen", 32'(got), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_noresp", 32'(resp_valid2), 32'd0);
    chk("late_ack_idle", 32'(busy2), 32'd0);
    drive(1'b0, 3'b101, 32'h0000_0042, 32'h0, 5'd12);
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    chk("to2_req", 32'(mem_req2), 32'd1);
    chk("to2_be", 32'(mem_be2), 32'(4'b1100));
    mem_ack = 1'b1;
    mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("to2_valid", 32'(resp_valid2), 32'd1);
    chk("to2_rdata", resp_rdata2, 32'h0000_8001);
    chk("to2_wb", 32'(resp_wb2), 32'd1);
    chk("to2_err", 32'(resp_err2), 32'd0);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Performs one byte/half/word access on the data-memory bus using a req/ack handshake, then returns the aligned, extended load data (or a store completion) to writeback.
- Detects misaligned accesses, illegal funct3 and bus timeouts, and reports them without touching memory where possible.

Parameters:
- MEM_TIMEOUT, 255: maximum number of cycles in ACCESS waiting for mem_ack before a timeout error. Valid range 1..1023.
- XLEN comes from riscv.h; it is fixed at 32 and is not a parameter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  XLEN  effective address (ALU out)
- req_wdata  in  XLEN  store data (rs2)
- req_rd  in  5  destination register, passed through
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and on error
- resp_rd  out  5  captured rd; 0 for stores
- resp_wb  out  1  write rd: load and no error
- resp_err  out  1  misaligned, illegal funct3 or timeout
- busy  out  1  state != IDLE
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  XLEN  word address; bits [1:0] are always 0
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  bus completion; rdata valid in the same cycle
- mem_rdata  in  XLEN  full read word

Behaviour:
- All outputs are registered or decoded from state only. There are no combinational paths from any req_* input or from mem_ack to any output.

Reset:
- reset_n=0 at a clock edge forces state=IDLE and the timeout counter to 0.
- It also clears resp_valid, resp_wb, resp_err, resp_rdata, resp_rd, mem_req, mem_we, mem_addr, mem_be and mem_wdata to 0.
- req_ready is 1 and busy is 0 after reset.
- Reset in ACCESS drops mem_req at that same edge with no response generated. Reset in RESP cancels the pending pulse.

States: IDLE, ACCESS, RESP.

IDLE:
- req_ready=1.
- On req_valid, the request is captured at the edge.
- Legal and aligned request: go to ACCESS with mem_req=1 and mem_* set.
- Otherwise: go to RESP with err=1 and no bus activity.

ACCESS:
- mem_req and all mem_* outputs are held stable until mem_ack.
- On mem_ack: drop mem_req, capture the extended data, go to RESP.
- Counter increments each ACCESS cycle without ack. When it reaches MEM_TIMEOUT: drop mem_req, err=1, go to RESP.
- An ack in the same cycle as the timeout wins over the timeout.

RESP:
- resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure.
- mem_ack seen outside ACCESS is ignored.

Latency:
- Request accepted at edge 0; mem_req is high in cycle 1.
- An ack in cycle k gives resp_valid in cycle k+1. Minimum is 2 cycles from accept to response; back-to-back throughput is 1 request per 3 cycles.
- Error responses found at accept time: resp_valid in cycle 1.

Legal funct3:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Anything else is illegal.

Alignment:
- Halfword requires addr[0]=0; word requires addr[1:0]=00. Bytes are always aligned.

Lane mapping:
- mem_addr = {addr[31:2],2'b00}.
- SB: mem_be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: mem_be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
- SW: mem_be = 1111; wdata = rs2.
- Loads: mem_be follows the same pattern as stores of that width; mem_we=0; mem_wdata=0.

Load extraction:
- Select the byte/half lane by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unmodified.

Response fields:
- Stores: resp_wb=0, resp_rdata=0, resp_rd=0.
- Errors: resp_wb=0 and resp_rdata=0; resp_rd still carries the captured rd for trap reporting.

Test Plan:
- LB, addr 0x0000_1003, mem_rdata 0x80FF_7F01, ack in cycle 1 -> resp_valid in cycle 2, resp_rdata 0xFFFF_FF80, resp_wb=1, mem_be=1000, mem_addr 0x0000_1000.
- SH, addr 0x22, rs2 0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata 0xABCD_ABCD, mem_addr 0x20; mem_* held stable over 5 wait cycles until ack; resp_wb=0.
- LW at 0x102 -> no mem_req ever asserted; resp_valid in cycle 1 with resp_err=1, resp_wb=0, resp_rdata=0. Then funct3=011 store -> same error response.
- MEM_TIMEOUT=4, LHU 0x40, never ack -> mem_req high for exactly 4 cycles, then resp_err=1. Next request is accepted normally; a late ack arriving in IDLE is ignored.
- reset_n=0 in the 2nd ACCESS cycle of an LW -> next cycle mem_req=0, resp_valid=0, req_ready=1; a new LBU 0x7 with rdata 0x8000_0000 returns 0x0000_0080.
- Request held high continuously, ack always in cycle 1 -> one response every 3 cycles; req_ready pattern 1,0,0 repeats.
